// File: rtl/multimac_sequencer.sv
// multimac_sequencer: host command sequencer for the multimac MIN/MAX/MADD core.
// Turns BEGIN/LOAD/EXEC commands into core reset, init, load and run phases,
// and returns the captured core result over a valid/ready stream.
module multimac_sequencer #(
   parameter int unsigned RUN_CYCLES = 20,
   parameter int unsigned CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_insn,
   input  logic [3:0]  cmd_index,
   input  logic [3:0]  cmd_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [12:0] res_data,
   output logic        busy,
   output logic        err,
   output logic        core_rst_n,
   output logic [1:0]  core_insn,
   output logic [3:0]  core_index,
   output logic [3:0]  core_data,
   output logic        core_load,
   output logic        core_run,
   input  logic [12:0] core_out
);

   localparam logic [1:0] OP_BEGIN = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_EXEC  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_INIT,
      S_LOAD,
      S_RUN,
      S_CAPT,
      S_RESP
   } state_t;

   state_t             state, state_nx;
   logic               armed, armed_nx;
   logic               err_nx;
   logic               res_valid_nx;
   logic [12:0]        res_data_nx;
   logic               core_rst_n_nx;
   logic [1:0]         core_insn_nx;
   logic [3:0]         core_index_nx;
   logic [3:0]         core_data_nx;
   logic               core_load_nx;
   logic               core_run_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               accept;

   // Handshake and status derived from registered state
   assign cmd_ready = (state == S_IDLE) && !res_valid;
   assign busy      = (state != S_IDLE) || res_valid;
   assign accept    = cmd_valid && cmd_ready;

   // State register and registered core/host outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         armed      <= 1'b0;
         err        <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= 13'd0;
         core_rst_n <= 1'b0;
         core_insn  <= 2'd0;
         core_index <= 4'd0;
         core_data  <= 4'd0;
         core_load  <= 1'b0;
         core_run   <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_nx;
         armed      <= armed_nx;
         err        <= err_nx;
         res_valid  <= res_valid_nx;
         res_data   <= res_data_nx;
         core_rst_n <= core_rst_n_nx;
         core_insn  <= core_insn_nx;
         core_index <= core_index_nx;
         core_data  <= core_data_nx;
         core_load  <= core_load_nx;
         core_run   <= core_run_nx;
         cnt        <= cnt_nx;
      end
   end

   // Next-state and next-output decode; core pins follow the state being entered
   always_comb begin
      state_nx      = state;
      armed_nx      = armed;
      err_nx        = err;
      res_valid_nx  = res_valid;
      res_data_nx   = res_data;
      core_insn_nx  = core_insn;
      core_index_nx = core_index;
      core_data_nx  = core_data;
      cnt_nx        = cnt;
      core_rst_n_nx = 1'b1;
      core_load_nx  = 1'b0;
      core_run_nx   = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_BEGIN: begin
                     core_insn_nx = cmd_insn;
                     err_nx       = 1'b0;
                     state_nx     = S_CLR;
                  end
                  OP_LOAD: begin
                     if (armed) begin
                        core_index_nx = cmd_index;
                        core_data_nx  = cmd_data;
                        state_nx      = S_LOAD;
                     end else begin
                        err_nx = 1'b1;
                     end
                  end
                  OP_EXEC: begin
                     if (armed) begin
                        cnt_nx   = CNT_W'(RUN_CYCLES);
                        state_nx = S_RUN;
                     end else begin
                        err_nx = 1'b1;
                     end
                  end
                  default: err_nx = 1'b1;
               endcase
            end
         end
         S_CLR:  state_nx = S_INIT;
         S_INIT: begin
            armed_nx = 1'b1;
            state_nx = S_IDLE;
         end
         S_LOAD: state_nx = S_IDLE;
         S_RUN: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               state_nx = S_CAPT;
            end
         end
         S_CAPT: begin
            res_data_nx  = core_out;
            res_valid_nx = 1'b1;
            armed_nx     = 1'b0;
            state_nx     = S_RESP;
         end
         S_RESP: begin
            if (res_ready) begin
               res_valid_nx = 1'b0;
               state_nx     = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      core_rst_n_nx = (state_nx != S_CLR);
      core_load_nx  = (state_nx == S_LOAD);
      core_run_nx   = (state_nx == S_RUN);
   end

endmodule

// File: tb/tb_multimac_sequencer.sv
// Directed bench for multimac_sequencer with a small behavioural core model.
module tb_multimac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_insn;
   logic [3:0]  cmd_index;
   logic [3:0]  cmd_data;
   logic        res_valid;
   logic        res_ready;
   logic [12:0] res_data;
   logic        busy;
   logic        err;
   logic        core_rst_n;
   logic [1:0]  core_insn;
   logic [3:0]  core_index;
   logic [3:0]  core_data;
   logic        core_load;
   logic        core_run;
   logic [12:0] core_out;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   multimac_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_insn   (cmd_insn),
      .cmd_index  (cmd_index),
      .cmd_data   (cmd_data),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .busy       (busy),
      .err        (err),
      .core_rst_n (core_rst_n),
      .core_insn  (core_insn),
      .core_index (core_index),
      .core_data  (core_data),
      .core_load  (core_load),
      .core_run   (core_run),
      .core_out   (core_out)
   );

   // Core model: latches the last load, publishes {data,index} while running
   logic [3:0]  m_idx;
   logic [3:0]  m_data;
   logic [12:0] m_out;
   always @(posedge clk) begin
      if (!core_rst_n) begin
         m_idx  <= 4'd0;
         m_data <= 4'd0;
         m_out  <= 13'd0;
      end else begin
         if (core_load) begin
            m_idx  <= core_index;
            m_data <= core_data;
         end
         if (core_run) m_out <= {5'd0, m_data, m_idx};
      end
   end
   assign core_out = m_out;

   // Edge counters for run, load and core-reset activity
   int run_count    = 0;
   int load_count   = 0;
   int rstlow_count = 0;
   always @(posedge clk) begin
      if (core_run) run_count <= run_count + 1;
      if (core_load) load_count <= load_count + 1;
      if (rst_n && !core_rst_n) rstlow_count <= rstlow_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", 32'(cmd_ready), 32'd1);
   endtask

   // Issue one command when ready; returns at the negedge after acceptance
   task automatic send(input logic [1:0] op, input logic [1:0] insn,
                       input logic [3:0] idx, input logic [3:0] data);
      wait_ready();
      cmd_op    = op;
      cmd_insn  = insn;
      cmd_index = idx;
      cmd_data  = data;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_result();
      int n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_result", 32'(res_valid), 32'd1);
   endtask

   initial begin
      int r0;
      int l0;
      int k0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_insn  = 2'd0;
      cmd_index = 4'd0;
      cmd_data  = 4'd0;
      res_ready = 1'b0;

      // Reset values
      @(negedge clk);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_res_valid",  32'(res_valid),  32'd0);
      check("rst_core_run",   32'(core_run),   32'd0);
      check("rst_err",        32'(err),        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rel_busy",      32'(busy),      32'd0);
      @(negedge clk);
      check("rel_core_rst_n", 32'(core_rst_n), 32'd1);
      check("rel_res_valid",  32'(res_valid),  32'd0);

      // BEGIN: one CLR cycle, one INIT cycle, then ready
      k0 = rstlow_count;
      send(2'b00, 2'b01, 4'd0, 4'd0);
      check("beg_clr_rst_n",  32'(core_rst_n), 32'd0);
      check("beg_clr_ready",  32'(cmd_ready),  32'd0);
      check("beg_insn",       32'(core_insn),  32'd1);
      @(negedge clk);
      check("beg_init_rst_n", 32'(core_rst_n), 32'd1);
      check("beg_init_ready", 32'(cmd_ready),  32'd0);
      @(negedge clk);
      check("beg_done_ready", 32'(cmd_ready),  32'd1);
      check("beg_done_insn",  32'(core_insn),  32'd1);
      check("beg_rstlow_cnt", 32'(rstlow_count - k0), 32'd1);

      // BEGIN 00, LOAD idx 5, EXEC
      send(2'b00, 2'b00, 4'd0, 4'd0);
      l0 = load_count;
      send(2'b01, 2'b00, 4'd5, 4'd0);
      check("ld_strobe", 32'(core_load),  32'd1);
      check("ld_index",  32'(core_index), 32'd5);
      check("ld_insn",   32'(core_insn),  32'd0);
      @(negedge clk);
      check("ld_strobe_off", 32'(core_load), 32'd0);
      check("ld_count", 32'(load_count - l0), 32'd1);
      r0 = run_count;
      send(2'b10, 2'b00, 4'd0, 4'd0);
      check("ex_run_on", 32'(core_run), 32'd1);
      wait_result();
      check("ex_run_cycles", 32'(run_count - r0), 32'd20);
      check("ex_res_data",   32'(res_data), 32'd5);
      check("ex_run_off",    32'(core_run), 32'd0);
      repeat (3) @(negedge clk);
      check("ex_hold_valid", 32'(res_valid), 32'd1);
      check("ex_hold_data",  32'(res_data),  32'd5);
      check("ex_hold_ready", 32'(cmd_ready), 32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("ex_hs_valid", 32'(res_valid), 32'd0);
      check("ex_hs_ready", 32'(cmd_ready), 32'd1);
      check("ex_hs_busy",  32'(busy),      32'd0);

      // Unarmed EXEC, reserved op and unarmed LOAD all flag err
      r0 = run_count;
      l0 = load_count;
      send(2'b10, 2'b00, 4'd0, 4'd0);
      check("er_exec_err",   32'(err),       32'd1);
      check("er_exec_ready", 32'(cmd_ready), 32'd1);
      check("er_exec_busy",  32'(busy),      32'd0);
      send(2'b11, 2'b00, 4'd0, 4'd0);
      check("er_rsvd_err", 32'(err), 32'd1);
      send(2'b01, 2'b00, 4'd3, 4'd3);
      check("er_load_err", 32'(err), 32'd1);
      @(negedge clk);
      check("er_no_run",  32'(run_count - r0),  32'd0);
      check("er_no_load", 32'(load_count - l0), 32'd0);
      check("er_core_idx_held", 32'(core_index), 32'd5);
      send(2'b00, 2'b10, 4'd0, 4'd0);
      check("er_begin_clears", 32'(err), 32'd0);

      // Result held while host stalls
      send(2'b01, 2'b00, 4'd9, 4'd3);
      send(2'b10, 2'b00, 4'd0, 4'd0);
      wait_result();
      check("st_res_data", 32'(res_data),  32'h39);
      check("st_insn",     32'(core_insn), 32'd2);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("st_data",  32'(res_data),  32'h39);
         check("st_ready", 32'(cmd_ready), 32'd0);
         check("st_busy",  32'(busy),      32'd1);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("st_hs_valid", 32'(res_valid), 32'd0);

      // Async reset in RUN cycle 7 discards the job and disarms
      send(2'b00, 2'b01, 4'd0, 4'd0);
      send(2'b01, 2'b00, 4'd7, 4'd1);
      send(2'b10, 2'b00, 4'd0, 4'd0);
      repeat (6) @(negedge clk);
      check("ar_running", 32'(core_run), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ar_run_off",   32'(core_run),   32'd0);
      check("ar_res_valid", 32'(res_valid),  32'd0);
      check("ar_rst_n",     32'(core_rst_n), 32'd0);
      check("ar_insn",      32'(core_insn),  32'd0);
      check("ar_busy",      32'(busy),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      r0 = run_count;
      send(2'b10, 2'b00, 4'd0, 4'd0);
      check("ar_exec_err", 32'(err), 32'd1);
      repeat (3) @(negedge clk);
      check("ar_no_run",   32'(run_count - r0), 32'd0);
      check("ar_no_valid", 32'(res_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
